// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC channel: FSM state encoding,
// flag bit positions and the result record held while a measurement is valid.
// Result fields use the widest legal sizes; each instance uses the low bits.
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ARMED = 2'd2,
    ST_HOLD  = 2'd3
  } tdc_state_e;

  localparam int unsigned FLG_SAT = 0;
  localparam int unsigned FLG_BUB = 1;
  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_TMO = 3;

  // COARSE_W may be at most 32; N at most 256, so 9 fine bits.
  localparam int unsigned TDC_COARSE_WMAX = 32;
  localparam int unsigned TDC_FINE_WMAX   = 9;

  typedef struct packed {
    logic [TDC_COARSE_WMAX-1:0] coarse;
    logic [TDC_FINE_WMAX-1:0]   fine;
    logic [3:0]                 flags;
  } tdc_meas_t;

endpackage

// File: rtl/delay_line.sv
// Tapped delay line: hit propagates through N cells, every cell output is a tap.
// Latency: purely combinational (physical cell delay only).
// Ports: dl_in = asynchronous hit, dl_out = raw tap vector (RCA taps are active-low).
module delay_line #(
  parameter int unsigned N       = 64,
  parameter string       DL_TYPE = "RCA"
) (
  input  logic         dl_in,
  output logic [N-1:0] dl_out
);

  // One node per cell so the chain is a series of distinct nets, not a
  // self-referencing vector.
  for (genvar i = 0; i < N; i++) begin : g_tap
    logic node;

    if (i == 0) begin : g_head
      assign node = dl_in;
    end else if (DL_TYPE == "DAND") begin : g_dand
      assign node = g_tap[i-1].node & dl_in;
    end else begin : g_rca
      // Adder cell with a=1, b=0: carry out equals carry in.
      assign node = g_tap[i-1].node;
    end

    if (DL_TYPE == "DAND") begin : g_out_dand
      assign dl_out[i] = node;
    end else begin : g_out_rca
      // Sum output of the a=1, b=0 cell is the inverted carry in.
      assign dl_out[i] = ~node;
    end
  end

endmodule

// File: rtl/tdc_therm_decode.sv
// Thermometer decoder for the synchronised tap vector.
// Latency: combinational.
// Ports: taps_i = normalised taps; fine_o = leading-ones count from tap 0,
//        bubble_o = a one above the first zero, saturated_o = all taps one.
module tdc_therm_decode #(
  parameter  int unsigned N      = 64,
  localparam int unsigned FINE_W = $clog2(N + 1)
) (
  input  logic [N-1:0]      taps_i,
  output logic [FINE_W-1:0] fine_o,
  output logic              bubble_o,
  output logic              saturated_o
);

  logic seen_zero;

  always_comb begin
    fine_o    = '0;
    bubble_o  = 1'b0;
    seen_zero = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!taps_i[i]) begin
        seen_zero = 1'b1;
      end else if (seen_zero) begin
        bubble_o = 1'b1;
      end else begin
        fine_o = FINE_W'(i + 1);
      end
    end
  end

  assign saturated_o = &taps_i;

endmodule

// File: rtl/tdc_channel.sv
// Single-channel TDC front end: samples the delay line on clk, decodes the
// thermometer code and reports coarse/fine timestamps relative to an arm.
// Latency: tap captured at edge e -> result valid at edge e+2.
// Backpressure: result held stable in HOLD until meas_valid_o & meas_ready_i;
//               only the overflow flag may change while held.
// Ports: hit_i (async hit), arm_i (start window), meas_valid_o/meas_ready_i
//        (result handshake), coarse_o/fine_o/flags_o (result), busy_o (not IDLE).
module tdc_channel
  import tdc_pkg::*;
#(
  parameter  int unsigned N        = 64,
  parameter  string       DL_TYPE  = "RCA",
  parameter  bit          TAP_INV  = 1'b1,
  parameter  int unsigned COARSE_W = 8,
  localparam int unsigned FINE_W   = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hit_i,
  input  logic                arm_i,
  output logic                meas_valid_o,
  input  logic                meas_ready_i,
  output logic [COARSE_W-1:0] coarse_o,
  output logic [FINE_W-1:0]   fine_o,
  output logic [3:0]          flags_o,
  output logic                busy_o
);

  localparam logic [COARSE_W-1:0] COARSE_MAX = '1;
  // Last count from which one more idle ARMED cycle ends the window.
  localparam logic [COARSE_W-1:0] COARSE_TMO = {{(COARSE_W-1){1'b1}}, 1'b0};

  logic [N-1:0]      dl_out;
  logic [N-1:0]      dl_norm;
  logic [N-1:0]      tap_q;
  logic [N-1:0]      tap_s;
  logic              tap_ev_q;     // tap_s[0] one sample back, for rise detect
  logic [FINE_W-1:0] dec_fine;
  logic              dec_bub;
  logic              dec_sat;

  tdc_state_e          state_q, state_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  tdc_meas_t           meas_q, meas_d;

  delay_line #(
    .N       (N),
    .DL_TYPE (DL_TYPE)
  ) u_delay_line (
    .dl_in  (hit_i),
    .dl_out (dl_out)
  );

  assign dl_norm = dl_out ^ {N{TAP_INV}};

  tdc_therm_decode #(
    .N (N)
  ) u_decode (
    .taps_i      (tap_s),
    .fine_o      (dec_fine),
    .bubble_o    (dec_bub),
    .saturated_o (dec_sat)
  );

  always_comb begin
    state_d  = state_q;
    coarse_d = coarse_q;
    meas_d   = meas_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arm_i) state_d = ST_CLEAR;
      end

      // Wait for the line to drain so a stale hit is never timestamped.
      ST_CLEAR: begin
        if (tap_s == '0) begin
          state_d  = ST_ARMED;
          coarse_d = '0;
        end
      end

      // Event takes priority over timeout on the same edge.
      ST_ARMED: begin
        if (tap_s[0]) begin
          meas_d.coarse         = TDC_COARSE_WMAX'(coarse_q);
          meas_d.fine           = TDC_FINE_WMAX'(dec_fine);
          meas_d.flags          = '0;
          meas_d.flags[FLG_SAT] = dec_sat;
          meas_d.flags[FLG_BUB] = dec_bub;
          state_d               = ST_HOLD;
        end else if (coarse_q == COARSE_TMO) begin
          meas_d.coarse         = TDC_COARSE_WMAX'(COARSE_MAX);
          meas_d.fine           = '0;
          meas_d.flags          = '0;
          meas_d.flags[FLG_TMO] = 1'b1;
          state_d               = ST_HOLD;
        end else begin
          coarse_d = coarse_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (meas_ready_i) begin
          state_d = ST_IDLE;
          meas_d  = '0;
        end else if (tap_s[0] && !tap_ev_q) begin
          meas_d.flags[FLG_OVF] = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q    <= '0;
      tap_s    <= '0;
      tap_ev_q <= 1'b0;
      state_q  <= ST_IDLE;
      coarse_q <= '0;
      meas_q   <= '0;
    end else begin
      tap_q    <= dl_norm;
      tap_s    <= tap_q;
      tap_ev_q <= tap_s[0];
      state_q  <= state_d;
      coarse_q <= coarse_d;
      meas_q   <= meas_d;
    end
  end

  assign meas_valid_o = (state_q == ST_HOLD);
  assign busy_o       = (state_q != ST_IDLE);
  assign coarse_o     = COARSE_W'(meas_q.coarse);
  assign fine_o       = FINE_W'(meas_q.fine);
  assign flags_o      = meas_q.flags;

endmodule

// File: tb/tb_tdc_channel.sv
module tb_tdc_channel;

  logic        clk;
  logic        rst_n;
  logic        hit_i;
  logic        arm_i;
  logic        meas_valid_o;
  logic        meas_ready_i;
  logic [7:0]  coarse_o;
  logic [6:0]  fine_o;
  logic [3:0]  flags_o;
  logic        busy_o;

  logic [63:0] taps_drv;
  int          cyc;
  int          zclr;        // edge at which the last all-zero tap vector was captured
  int          n_chk;
  int          n_fail;
  int          e_coarse;
  int          e_fine;
  logic [3:0]  e_flags;

  tdc_channel dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hit_i        (hit_i),
    .arm_i        (arm_i),
    .meas_valid_o (meas_valid_o),
    .meas_ready_i (meas_ready_i),
    .coarse_o     (coarse_o),
    .fine_o       (fine_o),
    .flags_o      (flags_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_taps(input logic [63:0] v);
    taps_drv = v;
    force dut.dl_norm = taps_drv;
  endtask

  // Arm, optionally drain a tap vector left high, then present hit pattern p
  // so it is captured d edges after the arm edge. Checks latency and result.
  task automatic run_meas(input int d, input logic [63:0] p, input bit hit, input int clr_at);
    int k, a, c, edge_e;
    logic [63:0] t;
    bit tmo;
    @(negedge clk);
    arm_i = 1'b1;
    @(negedge clk);
    arm_i = 1'b0;
    k = cyc;
    chk("busy_after_arm", busy_o, 1);
    c = k + d;
    tmo = !hit;
    if (hit) begin
      while (cyc < c - 1) begin
        if (clr_at > 0 && cyc == k + clr_at - 1) begin
          set_taps('0);
          zclr = cyc + 1;
        end
        arm_i = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      arm_i = 1'b0;
      set_taps(p);
    end
    // First ARMED edge: one after the arm and after the drained taps are visible.
    a = ((k + 1) > (zclr + 2)) ? (k + 1) : (zclr + 2);
    if (hit) begin
      e_coarse = c + 1 - a;
      if (e_coarse > 254) tmo = 1'b1;
    end
    if (tmo) begin
      edge_e   = a + 255;
      e_coarse = 255;
      e_fine   = 0;
      e_flags  = 4'b1000;
    end else begin
      edge_e = c + 2;
      if (p == {64{1'b1}}) begin
        e_fine  = 64;
        e_flags = 4'b0001;
      end else begin
        t       = p ^ (p + 64'd1);
        e_fine  = $countones(t) - 1;
        e_flags = {2'b00, ((p >> e_fine) != 64'd0), 1'b0};
      end
    end
    while (meas_valid_o !== 1'b1 && cyc < edge_e + 4) @(negedge clk);
    chk("latency", 64'(cyc), 64'(edge_e));
    chk("valid", meas_valid_o, 1);
    chk("coarse", coarse_o, 64'(e_coarse));
    chk("fine", fine_o, 64'(e_fine));
    chk("flags", flags_o, e_flags);
  endtask

  task automatic handshake(input bit with_arm);
    meas_ready_i = 1'b1;
    arm_i        = with_arm;
    @(negedge clk);
    meas_ready_i = 1'b0;
    arm_i        = 1'b0;
    chk("hs_valid", meas_valid_o, 0);
    chk("hs_busy", busy_o, 0);
    chk("hs_flags", flags_o, 0);
    set_taps('0);
    zclr = cyc + 1;
    @(negedge clk);
    chk("idle_stays", busy_o, 0);
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_valid"}, meas_valid_o, 1);
    chk({tag, "_coarse"}, coarse_o, 64'(e_coarse));
    chk({tag, "_fine"}, fine_o, 64'(e_fine));
    chk({tag, "_flags"}, flags_o, e_flags);
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {meas_valid_o, busy_o, coarse_o, fine_o, flags_o}, 0);
  endtask

  initial begin
    logic [63:0] p;
    int          l;
    clk          = 1'b0;
    rst_n        = 1'b0;
    hit_i        = 1'b0;
    arm_i        = 1'b0;
    meas_ready_i = 1'b0;
    cyc          = 0;
    n_chk        = 0;
    n_fail       = 0;
    zclr         = 0;
    set_taps('0);

    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("idle_after_reset");

    // 17 leading ones captured 5 edges after arm.
    run_meas(5, 64'h1_FFFF, 1'b1, 0);
    chk("ex_coarse5", coarse_o, 5);
    chk("ex_fine17", fine_o, 17);
    handshake(1'b0);

    // Bubble: 8 leading ones plus a stray one at bit 20.
    run_meas(3, 64'h0000_0000_0010_00FF, 1'b1, 0);
    chk("bubble_flag", flags_o, 4'b0010);
    handshake(1'b0);

    // Saturation.
    run_meas(7, {64{1'b1}}, 1'b1, 0);
    chk("sat_flag", flags_o, 4'b0001);
    handshake(1'b0);

    // Held result stable under arm pulses; then handshake with arm same cycle.
    run_meas(4, 64'h7, 1'b1, 0);
    repeat (3) begin
      arm_i = 1'b1;
      @(negedge clk);
      arm_i = 1'b0;
      check_held("hold_arm");
    end
    handshake(1'b1);

    // Event on the last possible ARMED edge beats the timeout.
    run_meas(254, 64'h1, 1'b1, 0);
    chk("edge254_tmo", flags_o[3], 0);
    handshake(1'b0);

    // Timeout with no hit.
    run_meas(0, '0, 1'b0, 0);
    chk("tmo_coarse", coarse_o, 255);
    chk("tmo_flag", flags_o, 4'b1000);
    handshake(1'b0);

    // Arm while the line is still full: CLEAR waits for the drain.
    set_taps({64{1'b1}});
    repeat (3) @(negedge clk);
    run_meas(10, 64'h3F, 1'b1, 4);
    chk("clear_coarse", coarse_o, 5);
    handshake(1'b0);

    // Overflow: drop and re-raise taps while held.
    run_meas(3, 64'h1_FFFF, 1'b1, 0);
    set_taps('0);
    repeat (2) @(negedge clk);
    check_held("ovf_pre");
    set_taps(64'h1_FFFF);
    repeat (4) @(negedge clk);
    e_flags = e_flags | 4'b0100;
    check_held("ovf_post");
    handshake(1'b0);

    // Reset while ARMED.
    @(negedge clk);
    arm_i = 1'b1;
    @(negedge clk);
    arm_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_armed", busy_o, 1);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid_armed");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while HOLD.
    run_meas(6, 64'hFF, 1'b1, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid_hold");
    set_taps('0);
    zclr = cyc + 1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Randomised measurements.
    for (int it = 0; it < 14; it++) begin
      l = $urandom_range(1, 64);
      p = (l == 64) ? {64{1'b1}} : ((64'd1 << l) - 64'd1);
      if (l < 63 && $urandom_range(0, 1) == 1)
        p = p | (64'd1 << $urandom_range(l + 1, 63));
      run_meas($urandom_range(1, 40), p, 1'b1, 0);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check_held("rand_hold");
      end
      handshake(1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
